vu_level_tracker: RTL and testbench

VU_LEVEL_TRACKER -- requirements
Module: vu_level_tracker

---
 rtl/vu_pkg.sv | 12 +
 rtl/vu_tick_div.sv | 34 +++
 rtl/vu_level_tracker.sv | 147 ++++++++++++++
 tb/tb_vu_level_tracker.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vu_pkg.sv
// Shared definitions for the VU meter level tracker: bar width and peak-marker states.
package vu_pkg;

    localparam int LEVEL_W = 8;

    typedef enum logic [1:0] {
        TRACK = 2'd0,
        HOLD  = 2'd1,
        FALL  = 2'd2
    } peak_state_e;

endpackage

// File: rtl/vu_tick_div.sv
// Decay-rate divider: emits a one-cycle tick every DECAY_DIV enabled clk_board cycles.
module vu_tick_div #(
    parameter int DECAY_DIV = 4096
) (
    input  logic clk_board,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(DECAY_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DECAY_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_board) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/vu_level_tracker.sv
// VU bar level with attack/decay and an optional peak marker (hold, then fall).
// Build with VU_PEAK_HOLD_EN defined for the peak-hold FSM; otherwise peak mirrors level.
module vu_level_tracker
    import vu_pkg::*;
#(
    parameter int DECAY_DIV       = 4096,
    parameter int PEAK_HOLD_TICKS = 64
) (
    input  logic               clk_board,
    input  logic               reset,
    input  logic               enable,
    input  logic [LEVEL_W-1:0] sample,
    input  logic               sample_valid,
    output logic [LEVEL_W-1:0] level,
    output logic [LEVEL_W-1:0] peak,
    output logic               update
);

    if (DECAY_DIV < 2 || PEAK_HOLD_TICKS < 1) begin : g_cfg_check
        $error("vu_level_tracker: need DECAY_DIV >= 2 and PEAK_HOLD_TICKS >= 1");
    end

    function automatic logic [LEVEL_W-1:0] sat_dec(input logic [LEVEL_W-1:0] v);
        return (v == '0) ? v : v - LEVEL_W'(1);
    endfunction

    logic               tick;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;
    logic               update_q;
    logic               changed;

    vu_tick_div #(
        .DECAY_DIV (DECAY_DIV)
    ) u_tick_div (
        .clk_board (clk_board),
        .reset     (reset),
        .enable    (enable),
        .tick      (tick)
    );

    // Decay first, then let an attack win: a tick plus sample gives max(sample, level-1).
    always_comb begin
        level_d = level_q;
        if (enable) begin
            level_d = tick ? sat_dec(level_q) : level_q;
            if (sample_valid && (sample > level_d)) begin
                level_d = sample;
            end
        end
    end

    always_ff @(posedge clk_board) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

`ifdef VU_PEAK_HOLD_EN
    localparam int HOLD_W = $clog2(PEAK_HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(PEAK_HOLD_TICKS);

    peak_state_e        state_q;
    peak_state_e        state_d;
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_d;
    logic [LEVEL_W-1:0] peak_q;
    logic [LEVEL_W-1:0] peak_d;
    logic [LEVEL_W-1:0] peak_dec;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        peak_d   = peak_q;
        peak_dec = sat_dec(peak_q);
        if (enable) begin
            if (level_d > peak_q) begin
                peak_d  = level_d;
                hold_d  = HOLD_LOAD;
                state_d = HOLD;
            end else begin
                case (state_q)
                    TRACK: begin
                        peak_d = level_d;
                    end
                    HOLD: begin
                        if (tick) begin
                            if (hold_q <= HOLD_W'(1)) begin
                                hold_d  = '0;
                                state_d = FALL;
                            end else begin
                                hold_d = hold_q - HOLD_W'(1);
                            end
                        end
                    end
                    FALL: begin
                        // Once the falling marker reaches the bar it snaps on and tracks it.
                        if (tick) begin
                            if (peak_dec <= level_d) begin
                                peak_d  = level_d;
                                state_d = TRACK;
                            end else begin
                                peak_d = peak_dec;
                            end
                        end
                    end
                    default: begin
                        state_d = TRACK;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_board) begin
        if (reset) begin
            state_q <= TRACK;
            hold_q  <= '0;
            peak_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            peak_q  <= peak_d;
        end
    end

    assign peak    = peak_q;
    assign changed = (level_d != level_q) || (peak_d != peak_q);
`else
    assign peak    = level_q;
    assign changed = (level_d != level_q);
`endif

    always_ff @(posedge clk_board) begin
        if (reset) begin
            update_q <= 1'b0;
        end else begin
            update_q <= enable && changed;
        end
    end

    assign level  = level_q;
    assign update = update_q;

endmodule

// File: tb/tb_vu_level_tracker.sv
// Directed bench for vu_level_tracker (DECAY_DIV=4, PEAK_HOLD_TICKS=3); works with or without VU_PEAK_HOLD_EN.
module tb_vu_level_tracker;

    localparam int DIV  = 4;
    localparam int HOLD = 3;

    logic       clk_board = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] sample;
    logic       sample_valid;
    logic [7:0] level;
    logic [7:0] peak;
    logic       update;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_board = ~clk_board;

    vu_level_tracker #(
        .DECAY_DIV       (DIV),
        .PEAK_HOLD_TICKS (HOLD)
    ) dut (
        .clk_board    (clk_board),
        .reset        (reset),
        .enable       (enable),
        .sample       (sample),
        .sample_valid (sample_valid),
        .level        (level),
        .peak         (peak),
        .update       (update)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       sv;
        logic [7:0] smp;
        logic [7:0] lvl;
        logic [7:0] pk;   // peak with the hold FSM built
        logic       upd;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic r, input logic e, input logic s, input logic [7:0] d,
                                input logic [7:0] l, input logic [7:0] p, input logic u);
        vec_t v;
        v.rst = r; v.en = e; v.sv = s; v.smp = d; v.lvl = l; v.pk = p; v.upd = u;
        return v;
    endfunction

    function automatic logic [7:0] pick_pk(input logic [7:0] held, input logic [7:0] lvl);
`ifdef VU_PEAK_HOLD_EN
        return held;
`else
        return lvl;
`endif
    endfunction

    // Closed-form decay after an attack of a from rest: k ticks have elapsed.
    function automatic logic [7:0] exp_lvl(input int a, input int k);
        return 8'((a - k < 0) ? 0 : a - k);
    endfunction

    function automatic logic [7:0] exp_pk(input int a, input int k);
        int p;
        if (k <= HOLD) p = a;
        else p = (a + HOLD - k < 0) ? 0 : a + HOLD - k;
        return pick_pk(8'(p), exp_lvl(a, k));
    endfunction

    task automatic drive(input logic r, input logic e, input logic s, input logic [7:0] d);
        reset = r; enable = e; sample_valid = s; sample = d;
        @(posedge clk_board);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] el, input logic [7:0] ep, input logic eu);
        n_vec++;
        if (level !== el || peak !== ep || update !== eu) begin
            n_bad++;
            $display("FAIL %s: got level=%02h peak=%02h update=%0b, want level=%02h peak=%02h update=%0b",
                     name, level, peak, update, el, ep, eu);
        end
    endtask

    // Idle cycles j0..j0+n-1 after an attack of a made when the divider was at 0.
    task automatic run_decay(input string name, input int a, input int j0, input int n);
        for (int j = j0; j < j0 + n; j++) begin
            int   k;
            logic tk;
            logic eu;
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            k  = (j + 1) / DIV;
            tk = ((j % DIV) == DIV - 1);
            eu = tk && ((exp_lvl(a, k) != exp_lvl(a, k - 1)) || (exp_pk(a, k) != exp_pk(a, k - 1)));
            check($sformatf("%s_j%0d", name, j), exp_lvl(a, k), exp_pk(a, k), eu);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; sample_valid = 1'b0; sample = 8'h00;

        // reset state, sample below level, decay under a small sample, re-attack
        vecs[0]  = mk(1, 1, 1, 8'hAA, 8'h00, 8'h00, 0);
        vecs[1]  = mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        vecs[2]  = mk(0, 1, 1, 8'h80, 8'h80, 8'h80, 1);
        vecs[3]  = mk(0, 1, 1, 8'h55, 8'h80, 8'h80, 0);
        vecs[4]  = mk(0, 1, 0, 8'h00, 8'h80, 8'h80, 0);
        vecs[5]  = mk(0, 1, 1, 8'h55, 8'h7F, 8'h80, 1);
        vecs[6]  = mk(0, 1, 1, 8'h81, 8'h81, 8'h81, 1);
        // sample equal to level on a tick cycle suppresses the decrement
        vecs[7]  = mk(1, 1, 0, 8'h00, 8'h00, 8'h00, 0);
        vecs[8]  = mk(0, 1, 1, 8'h90, 8'h90, 8'h90, 1);
        vecs[9]  = mk(0, 1, 0, 8'h00, 8'h90, 8'h90, 0);
        vecs[10] = mk(0, 1, 0, 8'h00, 8'h90, 8'h90, 0);
        vecs[11] = mk(0, 1, 1, 8'h90, 8'h90, 8'h90, 0);
        vecs[12] = mk(0, 1, 0, 8'h00, 8'h90, 8'h90, 0);
        vecs[13] = mk(0, 1, 0, 8'h00, 8'h90, 8'h90, 0);
        vecs[14] = mk(0, 1, 0, 8'h00, 8'h90, 8'h90, 0);
        vecs[15] = mk(0, 1, 0, 8'h00, 8'h8F, 8'h90, 1);
        // full scale held by repeated 0xFF samples
        vecs[16] = mk(1, 1, 0, 8'h00, 8'h00, 8'h00, 0);
        vecs[17] = mk(0, 1, 1, 8'hFF, 8'hFF, 8'hFF, 1);
        vecs[18] = mk(0, 1, 1, 8'hFF, 8'hFF, 8'hFF, 0);
        vecs[19] = mk(0, 1, 1, 8'hFF, 8'hFF, 8'hFF, 0);
        vecs[20] = mk(0, 1, 1, 8'hFF, 8'hFF, 8'hFF, 0);
        // decay saturates at zero
        vecs[21] = mk(1, 1, 0, 8'h00, 8'h00, 8'h00, 0);
        vecs[22] = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
        vecs[23] = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
        vecs[24] = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
        vecs[25] = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 0);

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].sv, vecs[i].smp);
            check($sformatf("vec%0d", i), vecs[i].lvl, pick_pk(vecs[i].pk, vecs[i].lvl), vecs[i].upd);
        end

        // attack 0xAA then decay all the way to zero, peak held then falling
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("decay_rst", 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'hAA);
        check("decay_attack", 8'hAA, 8'hAA, 1'b1);
        run_decay("decay", 8'hAA, 1, 700);

        // freeze for 20 cycles mid-hold, then the countdown resumes
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("frz_rst", 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h60);
        check("frz_attack", 8'h60, 8'h60, 1'b1);
        run_decay("frz_pre", 8'h60, 1, 3);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'(i % 2), 8'hF0);
            check($sformatf("frz_hold%0d", i), 8'h5F, pick_pk(8'h60, 8'h5F), 1'b0);
        end
        run_decay("frz_post", 8'h60, 4, 12);

        // reset during the fall with peak at 0x70
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("fall_rst0", 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h71);
        check("fall_attack", 8'h71, 8'h71, 1'b1);
        run_decay("fall", 8'h71, 1, 16);
        check("fall_at70", 8'h6D, pick_pk(8'h70, 8'h6D), 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h50);
        check("fall_rst", 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        check("fall_idle", 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h20);
        check("fall_reattack", 8'h20, 8'h20, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
